// File: rtl/chacha20_pkg.sv
// Shared ChaCha20 types, sigma constants, quarter-round index tables and the
// quarter-round helper used by the round datapath.
package chacha20_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [15:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_ADD,
    ST_DONE
  } state_e;

  // Word i of the packed vector is SIGMA[i]: "expand 32-byte k".
  localparam logic [3:0][31:0] SIGMA = {
    32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865
  };

  // Four quarter-rounds per table, each listed as (a, b, c, d).
  localparam logic [3:0] COL_IDX [16] = '{
    4'd0, 4'd4, 4'd8,  4'd12,
    4'd1, 4'd5, 4'd9,  4'd13,
    4'd2, 4'd6, 4'd10, 4'd14,
    4'd3, 4'd7, 4'd11, 4'd15
  };

  localparam logic [3:0] DIAG_IDX [16] = '{
    4'd0, 4'd5, 4'd10, 4'd15,
    4'd1, 4'd6, 4'd11, 4'd12,
    4'd2, 4'd7, 4'd8,  4'd13,
    4'd3, 4'd4, 4'd9,  4'd14
  };

  function automatic word_t rotl(word_t x, int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Returns {a, b, c, d} after one quarter-round.
  function automatic logic [127:0] quarter_round(word_t a_in, word_t b_in,
                                                 word_t c_in, word_t d_in);
    word_t a, b, c, d;
    a = a_in; b = b_in; c = c_in; d = d_in;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

endpackage

// File: rtl/chacha20_block_if.sv
// Request / keystream interface of chacha20_block. counter_load exists only
// when CHACHA20_COUNTER_AUTOINC_EN is defined.
interface chacha20_block_if;
  // valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high; the valid side holds valid and its payload stable until then.
  logic         start_valid;
  logic         start_ready;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  counter;
`ifdef CHACHA20_COUNTER_AUTOINC_EN
  logic         counter_load;
`endif
  logic         ks_valid;
  logic         ks_ready;
  logic [511:0] keystream;
  logic [31:0]  ks_counter;
  logic         busy;

  modport slave (
`ifdef CHACHA20_COUNTER_AUTOINC_EN
    input  counter_load,
`endif
    input  start_valid, key, nonce, counter, ks_ready,
    output start_ready, ks_valid, keystream, ks_counter, busy
  );

  modport master (
`ifdef CHACHA20_COUNTER_AUTOINC_EN
    output counter_load,
`endif
    output start_valid, key, nonce, counter, ks_ready,
    input  start_ready, ks_valid, keystream, ks_counter, busy
  );
endinterface

// File: rtl/chacha20_round.sv
// One ChaCha20 round, combinational: four parallel quarter-rounds on either
// the column or the diagonal word groups, selected by i_diag.
module chacha20_round
  import chacha20_pkg::*;
(
  input  state_t i_state,
  input  logic   i_diag,
  output state_t o_state
);

  word_t w_in  [4][4];
  word_t w_out [4][4];

  for (genvar q = 0; q < 4; q++) begin : g_qr
    for (genvar p = 0; p < 4; p++) begin : g_sel
      assign w_in[q][p] = i_diag ? i_state[DIAG_IDX[4*q+p]] : i_state[COL_IDX[4*q+p]];
    end
    assign {w_out[q][0], w_out[q][1], w_out[q][2], w_out[q][3]} =
      quarter_round(w_in[q][0], w_in[q][1], w_in[q][2], w_in[q][3]);
  end

  // Word k sits at position k/4 of column group k%4, and of diagonal group
  // (k%4 - k/4) mod 4.
  for (genvar k = 0; k < 16; k++) begin : g_out
    localparam int P  = k / 4;
    localparam int CQ = k % 4;
    localparam int DQ = ((k % 4) - (k / 4) + 4) % 4;
    assign o_state[k] = i_diag ? w_out[DQ][P] : w_out[CQ][P];
  end

endmodule

// File: rtl/chacha20_block.sv
// Iterative ChaCha20 block engine: one round per clock, then feed-forward add.
// Optional feature macro: CHACHA20_COUNTER_AUTOINC_EN (internal block counter).
module chacha20_block
  import chacha20_pkg::*;
#(
  parameter int ROUNDS = 20  // even, >= 2
) (
  input  logic               clk,
  input  logic               rst_n,
  chacha20_block_if.slave    bus,
  output state_e             o_dbg_state
);

  localparam int RW = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;
  localparam logic [RW-1:0] LAST = RW'(ROUNDS - 1);

  state_e        r_fsm;
  state_t        r_work;
  state_t        r_init;
  logic [RW-1:0] r_round;
  state_t        r_keystream;
  logic [31:0]   r_ks_counter;
  logic          r_ks_valid;
  logic          r_start_ready;
  logic          r_busy;

  word_t  w_ctr;
  state_t w_init;
  state_t w_next;
  state_t w_sum;

`ifdef CHACHA20_COUNTER_AUTOINC_EN
  logic [31:0] r_auto_ctr;
  assign w_ctr = bus.counter_load ? bus.counter : r_auto_ctr;
`else
  assign w_ctr = bus.counter;
`endif

  assign w_init = {bus.nonce, w_ctr, bus.key, SIGMA};

  chacha20_round u_round (
    .i_state (r_work),
    .i_diag  (r_round[0]),
    .o_state (w_next)
  );

  for (genvar k = 0; k < 16; k++) begin : g_sum
    assign w_sum[k] = r_work[k] + r_init[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm         <= ST_IDLE;
      r_work        <= '0;
      r_init        <= '0;
      r_round       <= '0;
      r_keystream   <= '0;
      r_ks_counter  <= '0;
      r_ks_valid    <= 1'b0;
      r_start_ready <= 1'b1;
      r_busy        <= 1'b0;
`ifdef CHACHA20_COUNTER_AUTOINC_EN
      r_auto_ctr    <= '0;
`endif
    end else begin
      case (r_fsm)
        ST_IDLE: if (bus.start_valid) begin
          r_work        <= w_init;
          r_init        <= w_init;
          r_round       <= '0;
          r_start_ready <= 1'b0;
          r_busy        <= 1'b1;
          r_fsm         <= ST_ROUND;
        end
        ST_ROUND: begin
          r_work  <= w_next;
          r_round <= r_round + 1'b1;
          if (r_round == LAST) r_fsm <= ST_ADD;
        end
        ST_ADD: begin
          r_keystream  <= w_sum;
          r_ks_counter <= r_init[12];
          r_ks_valid   <= 1'b1;
          r_busy       <= 1'b0;
          r_fsm        <= ST_DONE;
`ifdef CHACHA20_COUNTER_AUTOINC_EN
          r_auto_ctr   <= r_init[12] + 32'd1;
`endif
        end
        ST_DONE: if (bus.ks_ready) begin
          r_ks_valid    <= 1'b0;
          r_start_ready <= 1'b1;
          r_fsm         <= ST_IDLE;
        end
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

  assign bus.start_ready = r_start_ready;
  assign bus.ks_valid    = r_ks_valid;
  assign bus.keystream   = r_keystream;
  assign bus.ks_counter  = r_ks_counter;
  assign bus.busy        = r_busy;
  assign o_dbg_state     = r_fsm;

endmodule

// File: tb/tb_chacha20_block.sv
// Directed bench for chacha20_block: RFC 8439 vector, backpressure, queued
// request, counter wrap, mid-block reset and a reduced-round instance.
module tb_chacha20_block;
  import chacha20_pkg::*;

  localparam logic [255:0] RFC_KEY = {
    32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
    32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100
  };
  localparam logic [95:0]  RFC_NONCE = {32'h00000000, 32'h4a000000, 32'h09000000};
  localparam logic [511:0] RFC_KS = {
    32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
    32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
    32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
    32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110
  };
  localparam logic [255:0] KEY_A = {8{32'hdeadbeef}} ^ {8{32'h01234567}};
  localparam logic [255:0] KEY_B = {4{64'h0011223344556677}};
  localparam logic [95:0]  NONCE_A = 96'h0000_0001_0000_0002_0000_0003;
  localparam logic [95:0]  NONCE_B = 96'hffff_eeee_dddd_cccc_bbbb_aaaa;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  state_e dbg, dbg8;
  chacha20_block_if bus ();
  chacha20_block_if b8 ();

  chacha20_block #(.ROUNDS(20)) dut (
    .clk (clk), .rst_n (rst_n), .bus (bus), .o_dbg_state (dbg)
  );
  chacha20_block #(.ROUNDS(8)) dut8 (
    .clk (clk), .rst_n (rst_n), .bus (b8), .o_dbg_state (dbg8)
  );

  // Reference model
  function automatic logic [127:0] mqr(logic [31:0] a_i, logic [31:0] b_i,
                                       logic [31:0] c_i, logic [31:0] d_i);
    logic [31:0] a, b, c, d;
    a = a_i; b = b_i; c = c_i; d = d_i;
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] model(logic [255:0] k, logic [95:0] n,
                                         logic [31:0] c, int rounds);
    logic [31:0] s [16];
    logic [31:0] x [16];
    logic [511:0] o;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
    s[12] = c;
    for (int j = 0; j < 3; j++) s[13+j] = n[32*j +: 32];
    x = s;
    for (int r = 0; r < rounds / 2; r++) begin
      {x[0], x[4], x[8],  x[12]} = mqr(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = mqr(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = mqr(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = mqr(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = mqr(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = mqr(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = mqr(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = mqr(x[3], x[4], x[9],  x[14]);
    end
    for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i] + s[i];
    return o;
  endfunction

  // Scoreboard checks
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_main(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    int w;
    w = 0;
    bus.key = k; bus.nonce = n; bus.counter = c; bus.start_valid = 1'b1;
    while (!bus.start_ready && w < 200) begin tick(); w++; end
    chk1("start_wait_main", (w < 200), 1'b1);
    tick();
    bus.start_valid = 1'b0;
  endtask

  task automatic wait_main(output int lat);
    lat = 0;
    while (!bus.ks_valid && lat < 100) begin tick(); lat++; end
  endtask

  task automatic handshake_main();
    bus.ks_ready = 1'b1;
    tick();
    bus.ks_ready = 1'b0;
  endtask

  task automatic start8(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    int w;
    w = 0;
    b8.key = k; b8.nonce = n; b8.counter = c; b8.start_valid = 1'b1;
    while (!b8.start_ready && w < 200) begin tick(); w++; end
    chk1("start_wait_r8", (w < 200), 1'b1);
    tick();
    b8.start_valid = 1'b0;
  endtask

  task automatic wait8(output int lat);
    lat = 0;
    while (!b8.ks_valid && lat < 100) begin tick(); lat++; end
  endtask

  task automatic handshake8();
    b8.ks_ready = 1'b1;
    tick();
    b8.ks_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [511:0] snap;
    logic stable;
    logic [255:0] rk;
    logic [95:0] rn;
    logic [31:0] rc;

    bus.start_valid = 1'b0; bus.ks_ready = 1'b0;
    bus.key = '0; bus.nonce = '0; bus.counter = '0;
    b8.start_valid = 1'b0; b8.ks_ready = 1'b0;
    b8.key = '0; b8.nonce = '0; b8.counter = '0;
`ifdef CHACHA20_COUNTER_AUTOINC_EN
    bus.counter_load = 1'b1;
    b8.counter_load = 1'b1;
`endif

    tick(); tick();
    chk1("rst_start_ready", bus.start_ready, 1'b1);
    chk1("rst_ks_valid", bus.ks_valid, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk("rst_keystream", bus.keystream, '0);
    chk32("rst_ks_counter", bus.ks_counter, 32'd0);
    chk32("rst_state", 32'(dbg), 32'(ST_IDLE));
    rst_n = 1'b1;
    tick();

    // RFC 8439 block function vector, consumer holding ks_ready low
    start_main(RFC_KEY, RFC_NONCE, 32'd1);
    chk1("rfc_busy_round", bus.busy, 1'b1);
    chk32("rfc_state_round", 32'(dbg), 32'(ST_ROUND));
    wait_main(lat);
    chk32("rfc_latency", 32'(lat), 32'd21);
    chk32("rfc_word0", bus.keystream[31:0], 32'he4e7f110);
    chk32("rfc_word1", bus.keystream[63:32], 32'h15593bd1);
    chk("rfc_block", bus.keystream, RFC_KS);
    chk32("rfc_ks_counter", bus.ks_counter, 32'd1);
    chk1("rfc_busy_done", bus.busy, 1'b0);

    // Backpressure: 50 cycles in DONE
    snap = bus.keystream;
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.keystream !== snap || bus.ks_valid !== 1'b1 ||
          bus.start_ready !== 1'b0 || bus.ks_counter !== 32'd1) stable = 1'b0;
    end
    chk1("bp_stable", stable, 1'b1);
    handshake_main();
    chk1("bp_valid_after_hs", bus.ks_valid, 1'b0);
    chk1("bp_ready_after_hs", bus.start_ready, 1'b1);

    // Second request with new inputs presented while a block is in flight
    start_main(KEY_A, NONCE_A, 32'h00000007);
    repeat (5) tick();
    bus.key = KEY_B; bus.nonce = NONCE_B; bus.counter = 32'h89abcdef;
    bus.start_valid = 1'b1;
    tick();
    chk1("queued_start_ready", bus.start_ready, 1'b0);
    wait_main(lat);
    chk("queued_first_block", bus.keystream, model(KEY_A, NONCE_A, 32'h00000007, 20));
    chk32("queued_first_ctr", bus.ks_counter, 32'h00000007);
    handshake_main();
    start_main(KEY_B, NONCE_B, 32'h89abcdef);
    wait_main(lat);
    chk32("queued_second_latency", 32'(lat), 32'd21);
    chk("queued_second_block", bus.keystream, model(KEY_B, NONCE_B, 32'h89abcdef, 20));
    handshake_main();

    // Counter at 0xFFFFFFFF
    start_main(KEY_B, NONCE_A, 32'hffffffff);
    wait_main(lat);
    chk32("wrap_ks_counter", bus.ks_counter, 32'hffffffff);
    chk("wrap_block", bus.keystream, model(KEY_B, NONCE_A, 32'hffffffff, 20));
    handshake_main();
`ifdef CHACHA20_COUNTER_AUTOINC_EN
    bus.counter_load = 1'b0;
    start_main(KEY_A, NONCE_B, 32'h12345678);
    wait_main(lat);
    chk32("auto_wrap_ctr", bus.ks_counter, 32'h00000000);
    chk("auto_wrap_block", bus.keystream, model(KEY_A, NONCE_B, 32'h00000000, 20));
    handshake_main();
    start_main(KEY_A, NONCE_B, 32'h12345678);
    wait_main(lat);
    chk32("auto_next_ctr", bus.ks_counter, 32'h00000001);
    handshake_main();
    bus.counter_load = 1'b1;
`endif

    // Reset pulsed mid-block
    start_main(RFC_KEY, RFC_NONCE, 32'd1);
    repeat (10) tick();
    chk1("midrst_busy_before", bus.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("midrst_start_ready", bus.start_ready, 1'b1);
    chk1("midrst_ks_valid", bus.ks_valid, 1'b0);
    chk1("midrst_busy", bus.busy, 1'b0);
    chk("midrst_keystream", bus.keystream, '0);
    chk32("midrst_ks_counter", bus.ks_counter, 32'd0);
    chk32("midrst_state", 32'(dbg), 32'(ST_IDLE));
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk1("midrst_no_valid", bus.ks_valid, 1'b0);
    start_main(RFC_KEY, RFC_NONCE, 32'd1);
    wait_main(lat);
    chk32("midrst_rfc_latency", 32'(lat), 32'd21);
    chk("midrst_rfc_block", bus.keystream, RFC_KS);
    handshake_main();

    // Reduced-round instance against the model
    for (int i = 0; i < 100; i++) begin
      rk = {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
      rn = {$urandom(), $urandom(), $urandom()};
      rc = (i == 0) ? 32'hffffffff : $urandom();
      start8(rk, rn, rc);
      wait8(lat);
      chk32("r8_latency", 32'(lat), 32'd9);
      chk("r8_block", b8.keystream, model(rk, rn, rc, 8));
      chk32("r8_ks_counter", b8.ks_counter, rc);
      handshake8();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chacha20_block.md
# chacha20_block

Iterative ChaCha20 block-function engine. It builds the 16-word initial state from key, nonce and block counter, then drives a single round datapath through ROUNDS rounds. Rounds alternate between column and diagonal quarter-round groups, one round per clock. It then adds the initial state back in and presents a 512-bit keystream block on a valid/ready output. It sits between the cipher control/key registers and the keystream-XOR stage of the ChaCha20 core.

## Interface
- ROUNDS, 20, total rounds; must be even and ≥2 (20 = ChaCha20, 8/12 for reduced variants)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start_valid  in  1  request to compute one block
- start_ready  out  1  engine idle and able to accept a request
- key  in  256  key; state word 4+i = key[32i+31:32i]
- nonce  in  96  nonce; state word 13+j = nonce[32j+31:32j]
- counter  in  32  block counter for state word 12
- counter_load  in  1  present only with CHACHA20_COUNTER_AUTOINC_EN; take counter from port on this request
- ks_valid  out  1  keystream block available
- ks_ready  in  1  consumer accepts block
- keystream  out  512  output word i = keystream[32i+31:32i]
- ks_counter  out  32  counter value used for the presented block
- busy  out  1  high in ROUND or ADD

## Operation
- States: IDLE, ROUND, ADD, DONE.
- IDLE: start_ready=1. On start_valid, all inputs are sampled. Working state and saved initial state load as follows:
  - words 0–3 = 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574
  - words 4–11 = key; word 12 = counter; words 13–15 = nonce
  - round counter is cleared → ROUND.
- ROUND: one round per cycle.
  - Even round index (0,2,…): column QRs on (0,4,8,12)(1,5,9,13)(2,6,10,14)(3,7,11,15).
  - Odd round index: diagonal QRs on (0,5,10,15)(1,6,11,12)(2,7,8,13)(3,4,9,14).
  - After round ROUNDS-1 → ADD.
- ADD: keystream word i = working[i] + initial[i], mod 2^32 (carry discarded). ks_counter = initial word 12 → DONE.
- DONE: ks_valid=1. keystream and ks_counter are held stable until ks_valid&ks_ready, then → IDLE.
- Inputs changing after acceptance have no effect on the block in flight.
- start_ready=0 in every state except IDLE. A request presented during ROUND/ADD/DONE waits.

## Timing
- Reset values: start_ready=1, ks_valid=0, busy=0, keystream=0, ks_counter=0, state IDLE. Internal auto counter (if compiled) = 0.
- Request accepted on edge T. Rounds execute on edges T+1..T+ROUNDS. Add executes on edge T+ROUNDS+1, so ks_valid is high from that edge.
- Latency is ROUNDS+1 cycles (21 for default).
- If ks_ready=1 when ks_valid rises, the handshake completes on the next edge. start_ready is high the cycle after that.
- Minimum request-to-request spacing is ROUNDS+3 cycles.
- ks_valid never drops without a handshake, except on reset.
- rst_n asserted mid-operation: immediate return to reset values, block in flight discarded, no ks_valid.

## Configuration
- CHACHA20_COUNTER_AUTOINC_EN defined:
  - Internal 32-bit counter register exists.
  - On acceptance, word 12 = counter if counter_load=1, else the internal register.
  - At ADD the internal register becomes word12+1, wrapping 0xFFFFFFFF→0x00000000 with no flag.
- Macro undefined: counter_load port and internal register are absent, and word 12 always comes from counter.

## Structure
- Shared package chacha20_pkg: the four sigma constants; the word type (32-bit); the 16-word state array type; the state-enum type.
- The diagonal/column index tables also belong in chacha20_pkg.
- One sub-module, chacha20_round: purely combinational. It takes a 16-word state and a diag select, applies four parallel quarter-round datapaths (add/xor/rotate-left 16,12,8,7), and returns the new state.

## Test plan
- RFC 8439 §2.3.2: key 00..1f, nonce 00000009 0000004a 00000000, counter 1 → keystream word0 = 0xe4e7f110, word1 = 0x15593bd1, ks_valid exactly 21 cycles after acceptance.
- Backpressure: hold ks_ready=0 for 50 cycles in DONE → keystream and ks_valid stable, start_ready=0; release → handshake, start_ready=1 next cycle.
- Request during ROUND with changed key → ignored until IDLE; first block unaffected; second block matches the new key's model output.
- Counter = 0xFFFFFFFF with AUTOINC_EN, counter_load=1, then counter_load=0 → second block ks_counter = 0x00000000, matching the model.
- rst_n pulsed at round 10 → all outputs at reset values immediately; a subsequent RFC vector request produces the correct result.
- Reduced ROUNDS=8 build vs reference model, 100 random key/nonce/counter sets → bit-exact, latency 9 cycles.
